wb_commit: RTL and testbench

//  Write-back commit unit; consumes the MEM/WB pipeline-register bundle (wb_*) each cycle.

---
 rtl/wb_commit.sv | 179 +++++++++++++++++
 tb/tb_wb_commit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit.sv
// wb_commit: write-back commit unit.
// Holds the architectural GPR file, HI/LO and LLbit, applies the MEM/WB
// bundle writes every cycle and serves the ID-stage GPR reads and the
// EX-stage HI/LO/LLbit reads.
// Optional feature macro: WB_BYPASS_EN. When defined, the values being
// committed this cycle are forwarded to the read outputs in the same cycle.
// Without it, every output reflects stored state only.
module wb_commit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int REG_NUM = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wb_wreg,
    input  logic [ADDR_W-1:0] wb_wd,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              wb_whilo,
    input  logic [DATA_W-1:0] wb_hi,
    input  logic [DATA_W-1:0] wb_lo,
    input  logic              wb_LLbit_we,
    input  logic              wb_LLbit_value,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              LLbit_o
);

    // Entry 0 is never written, so it stays at its reset value of zero.
    logic [DATA_W-1:0] regs_r [REG_NUM];
    logic [DATA_W-1:0] hi_r;
    logic [DATA_W-1:0] lo_r;
    logic              llbit_r;

    logic [DATA_W-1:0] rdata1_s;
    logic [DATA_W-1:0] rdata2_s;
    logic [DATA_W-1:0] hi_s;
    logic [DATA_W-1:0] lo_s;
    logic              llbit_s;

    // GPR file: clear on reset, commit non-zero-address writes on each edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (wb_wreg && (wb_wd != {ADDR_W{1'b0}})) begin
                regs_r[wb_wd] <= wb_wdata;
            end
        end
    end

    // HI/LO pair: always written together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_r <= {DATA_W{1'b0}};
            lo_r <= {DATA_W{1'b0}};
        end else begin
            if (wb_whilo) begin
                hi_r <= wb_hi;
                lo_r <= wb_lo;
            end
        end
    end

    // LLbit: an exception flush breaks any outstanding LL/SC pair.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            llbit_r <= 1'b0;
        end else if (flush) begin
            llbit_r <= 1'b0;
        end else if (wb_LLbit_we) begin
            llbit_r <= wb_LLbit_value;
        end else begin
            llbit_r <= llbit_r;
        end
    end

    // GPR read port 1: gated by reset, enable and the zero register.
    always_comb begin
        rdata1_s = {DATA_W{1'b0}};
        if (!rst) begin
            rdata1_s = {DATA_W{1'b0}};
        end else if (!re1) begin
            rdata1_s = {DATA_W{1'b0}};
        end else if (raddr1 == {ADDR_W{1'b0}}) begin
            rdata1_s = {DATA_W{1'b0}};
        end else begin
`ifdef WB_BYPASS_EN
            if (wb_wreg && (raddr1 == wb_wd)) begin
                rdata1_s = wb_wdata;
            end else begin
                rdata1_s = regs_r[raddr1];
            end
`else
            rdata1_s = regs_r[raddr1];
`endif
        end
    end

    // GPR read port 2: same structure as port 1 so equal addresses match.
    always_comb begin
        rdata2_s = {DATA_W{1'b0}};
        if (!rst) begin
            rdata2_s = {DATA_W{1'b0}};
        end else if (!re2) begin
            rdata2_s = {DATA_W{1'b0}};
        end else if (raddr2 == {ADDR_W{1'b0}}) begin
            rdata2_s = {DATA_W{1'b0}};
        end else begin
`ifdef WB_BYPASS_EN
            if (wb_wreg && (raddr2 == wb_wd)) begin
                rdata2_s = wb_wdata;
            end else begin
                rdata2_s = regs_r[raddr2];
            end
`else
            rdata2_s = regs_r[raddr2];
`endif
        end
    end

    // HI/LO read: stored values, or the pair being committed when bypassing.
    always_comb begin
        hi_s = {DATA_W{1'b0}};
        lo_s = {DATA_W{1'b0}};
        if (!rst) begin
            hi_s = {DATA_W{1'b0}};
            lo_s = {DATA_W{1'b0}};
        end else begin
`ifdef WB_BYPASS_EN
            if (wb_whilo) begin
                hi_s = wb_hi;
                lo_s = wb_lo;
            end else begin
                hi_s = hi_r;
                lo_s = lo_r;
            end
`else
            hi_s = hi_r;
            lo_s = lo_r;
`endif
        end
    end

    // LLbit read: stored bit, or the bit about to be committed when bypassing.
    always_comb begin
        llbit_s = 1'b0;
        if (!rst) begin
            llbit_s = 1'b0;
        end else begin
`ifdef WB_BYPASS_EN
            if (flush) begin
                llbit_s = 1'b0;
            end else if (wb_LLbit_we) begin
                llbit_s = wb_LLbit_value;
            end else begin
                llbit_s = llbit_r;
            end
`else
            llbit_s = llbit_r;
`endif
        end
    end

    assign rdata1  = rdata1_s;
    assign rdata2  = rdata2_s;
    assign hi_o    = hi_s;
    assign lo_o    = lo_s;
    assign LLbit_o = llbit_s;

endmodule

// File: tb/tb_wb_commit.sv
// Directed self-checking bench for wb_commit (default or WB_BYPASS_EN build).
module tb_wb_commit;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        wb_wreg;
    logic [4:0]  wb_wd;
    logic [31:0] wb_wdata;
    logic        wb_whilo;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        wb_LLbit_we;
    logic        wb_LLbit_value;
    logic        re1;
    logic [4:0]  raddr1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        LLbit_o;

    int n_cmp = 0;
    int n_err = 0;

    wb_commit #(.DATA_W(32), .ADDR_W(5), .REG_NUM(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .wb_wreg(wb_wreg), .wb_wd(wb_wd), .wb_wdata(wb_wdata),
        .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
        .wb_LLbit_we(wb_LLbit_we), .wb_LLbit_value(wb_LLbit_value),
        .re1(re1), .raddr1(raddr1), .re2(re2), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2),
        .hi_o(hi_o), .lo_o(lo_o), .LLbit_o(LLbit_o)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change 1 unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bundle();
        flush = 1'b0; wb_wreg = 1'b0; wb_wd = 5'd0; wb_wdata = 32'h0;
        wb_whilo = 1'b0; wb_hi = 32'h0; wb_lo = 32'h0;
        wb_LLbit_we = 1'b0; wb_LLbit_value = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        idle_bundle();
        re1 = 1'b0; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd0;

        // Reset with writes of every kind presented: all must be dropped.
        wb_wreg = 1'b1; wb_wd = 5'd5; wb_wdata = 32'hDEAD_BEEF;
        wb_whilo = 1'b1; wb_hi = 32'h1111_1111; wb_lo = 32'h2222_2222;
        wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
        re1 = 1'b1; raddr1 = 5'd5;
        tick();
        tick();
        chk("rst_rdata1", rdata1, 32'h0);
        chk("rst_hi", hi_o, 32'h0);
        chk("rst_lo", lo_o, 32'h0);
        chk("rst_llbit", {31'd0, LLbit_o}, 32'h0);
        idle_bundle();
        #1;
        rst = 1'b1;
        #1;
        chk("post_rst_gpr5", rdata1, 32'h0);
        chk("post_rst_hi", hi_o, 32'h0);
        chk("post_rst_lo", lo_o, 32'h0);
        chk("post_rst_llbit", {31'd0, LLbit_o}, 32'h0);

        // Plain write then read next cycle.
        tick();
        wb_wreg = 1'b1; wb_wd = 5'd3; wb_wdata = 32'h1234_5678;
        tick();
        idle_bundle();
        raddr1 = 5'd3;
        #1;
        chk("gpr3_read", rdata1, 32'h1234_5678);

        // Write to register 0 is ignored.
        wb_wreg = 1'b1; wb_wd = 5'd0; wb_wdata = 32'hFFFF_FFFF;
        tick();
        idle_bundle();
        raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0;
        #1;
        chk("gpr0_port1", rdata1, 32'h0);
        chk("gpr0_port2", rdata2, 32'h0);

        // Highest address.
        wb_wreg = 1'b1; wb_wd = 5'd31; wb_wdata = 32'hCAFE_0031;
        tick();
        idle_bundle();
        raddr1 = 5'd31;
        #1;
        chk("gpr31_read", rdata1, 32'hCAFE_0031);

        // Same-cycle write/read hazard on register 7.
        wb_wreg = 1'b1; wb_wd = 5'd7; wb_wdata = 32'hA5A5_A5A5;
        raddr1 = 5'd7;
        #1;
`ifdef WB_BYPASS_EN
        chk("hazard_same_cycle", rdata1, 32'hA5A5_A5A5);
`else
        chk("hazard_same_cycle", rdata1, 32'h0);
`endif
        tick();
        idle_bundle();
        #1;
        chk("hazard_next_cycle", rdata1, 32'hA5A5_A5A5);

        // HI/LO write, then new data without enable must not land.
        wb_whilo = 1'b1; wb_hi = 32'h1; wb_lo = 32'h2;
        tick();
        wb_whilo = 1'b0; wb_hi = 32'h33; wb_lo = 32'h44;
        #1;
        chk("hi_written", hi_o, 32'h1);
        chk("lo_written", lo_o, 32'h2);
        tick();
        idle_bundle();
        #1;
        chk("hi_held", hi_o, 32'h1);
        chk("lo_held", lo_o, 32'h2);

        // LLbit set, then flush beats a simultaneous set.
        wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
        tick();
        idle_bundle();
        #1;
        chk("llbit_set", {31'd0, LLbit_o}, 32'h1);
        flush = 1'b1; wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
        // A GPR write in the flush cycle still commits.
        wb_wreg = 1'b1; wb_wd = 5'd9; wb_wdata = 32'h0909_0909;
        #1;
`ifdef WB_BYPASS_EN
        chk("llbit_flush_same", {31'd0, LLbit_o}, 32'h0);
`else
        chk("llbit_flush_same", {31'd0, LLbit_o}, 32'h1);
`endif
        tick();
        idle_bundle();
        raddr1 = 5'd9;
        #1;
        chk("llbit_flush_wins", {31'd0, LLbit_o}, 32'h0);
        chk("gpr9_flush_commit", rdata1, 32'h0909_0909);
        // Set again, then clear through the write port.
        wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
        tick();
        wb_LLbit_value = 1'b0;
        tick();
        idle_bundle();
        #1;
        chk("llbit_write_zero", {31'd0, LLbit_o}, 32'h0);

        // Read enables and equal addresses.
        re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b0; raddr2 = 5'd3;
        #1;
        chk("re2_off", rdata2, 32'h0);
        chk("re1_on", rdata1, 32'h1234_5678);
        re2 = 1'b1;
        #1;
        chk("dual_port1", rdata1, 32'h1234_5678);
        chk("dual_port2", rdata2, 32'h1234_5678);
        re1 = 1'b0;
        #1;
        chk("re1_off", rdata1, 32'h0);

        // Idle cycles: state holds.
        re1 = 1'b1; raddr1 = 5'd7; raddr2 = 5'd31;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        chk("hold_gpr7", rdata1, 32'hA5A5_A5A5);
        chk("hold_gpr31", rdata2, 32'hCAFE_0031);
        chk("hold_hi", hi_o, 32'h1);
        chk("hold_lo", lo_o, 32'h2);

        // Asynchronous reset mid-cycle clears everything immediately.
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_port1", rdata1, 32'h0);
        chk("async_rst_hi", hi_o, 32'h0);
        rst = 1'b1;
        #1;
        chk("async_rst_gpr31", rdata2, 32'h0);
        chk("async_rst_lo", lo_o, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
